cluster_core_start_sequencer: RTL and testbench



---
 rtl/cluster_core_start_sequencer.sv | 83 ++++++++
 tb/tb_cluster_core_start_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_core_start_sequencer.sv
// Staggered core-start sequencer: releases requested cores one at a time with a
// programmable gap to limit inrush, capturing each core's boot address at release.
module cluster_core_start_sequencer #(
  parameter int unsigned NB_CORES       = 8,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter logic [31:0] BOOT_ADDR      = 32'h1C000000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_CORES-1:0]      fetch_enable_i,
  input  logic [NB_CORES*32-1:0]   boot_addr_i,
  input  logic                     bypass_i,
  output logic [NB_CORES-1:0]      fetch_enable_o,
  output logic [NB_CORES*32-1:0]   boot_addr_o,
  output logic                     busy_o
);

  localparam int unsigned CNT_WIDTH = $clog2(STAGGER_CYCLES + 1);
  localparam bit          MULTI_GAP = (STAGGER_CYCLES > 1);
  // Release cycle itself counts as the first cycle of the gap, IDLE the last.
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD =
    CNT_WIDTH'(MULTI_GAP ? (STAGGER_CYCLES - 2) : 0);

  typedef enum logic {IDLE, GAP} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [NB_CORES-1:0]   pending;
  logic [NB_CORES-1:0]   lowest;
  logic [NB_CORES-1:0]   release_mask;

  // Pending is a level; lowest set bit isolated by two's-complement trick.
  always_comb begin
    pending      = fetch_enable_i & ~fetch_enable_o;
    lowest       = pending & (~pending + NB_CORES'(1));
    release_mask = '0;
    if (bypass_i) begin
      release_mask = pending;
    end else if (state == IDLE) begin
      release_mask = lowest;
    end
  end

  assign busy_o = (|pending) | (state == GAP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      fetch_enable_o <= '0;
      boot_addr_o    <= {NB_CORES{BOOT_ADDR}};
    end else begin
      // Deassert of dropped requests and new releases apply together.
      fetch_enable_o <= (fetch_enable_o & fetch_enable_i) | release_mask;
      for (int unsigned i = 0; i < NB_CORES; i++) begin
        if (release_mask[i]) begin
          boot_addr_o[i*32 +: 32] <= boot_addr_i[i*32 +: 32];
        end
      end
      case (state)
        IDLE: begin
          if (!bypass_i && (|pending) && MULTI_GAP) begin
            cnt   <= GAP_LOAD;
            state <= GAP;
          end
        end
        GAP: begin
          if (bypass_i || (cnt == '0)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_core_start_sequencer.sv
// Bench for cluster_core_start_sequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against an edge-count reference model.
module tb_cluster_core_start_sequencer;

  localparam int unsigned NC = 4;
  localparam logic [31:0] RST_ADDR = 32'h1C000000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   fe;
  logic [NC*32-1:0] ba;
  logic            byp;

  logic [NC-1:0]    fe_o4, fe_o1;
  logic [NC*32-1:0] ba_o4, ba_o1;
  logic             busy4, busy1;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  cluster_core_start_sequencer #(.NB_CORES(NC), .STAGGER_CYCLES(4), .BOOT_ADDR(RST_ADDR)) dut4 (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe), .boot_addr_i(ba), .bypass_i(byp),
    .fetch_enable_o(fe_o4), .boot_addr_o(ba_o4), .busy_o(busy4));

  cluster_core_start_sequencer #(.NB_CORES(NC), .STAGGER_CYCLES(1), .BOOT_ADDR(RST_ADDR)) dut1 (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe), .boot_addr_i(ba), .bypass_i(byp),
    .fetch_enable_o(fe_o1), .boot_addr_o(ba_o1), .busy_o(busy1));

  typedef struct {
    logic          rst_before;
    logic [NC-1:0] fe;
    logic          byp;
    logic [NC-1:0] exp4;
    logic          busy4;
    logic [NC-1:0] exp1;
    logic          chk_ba;
    logic [127:0]  exp_ba;
  } vec_t;

  vec_t tbl[$];

  localparam logic [127:0] PATTERN = {32'h1C000300, 32'h1C000200, 32'h1C000100, 32'h1C000000};
  localparam logic [127:0] ALL_RST = {4{32'h1C000000}};

  // Reference model: a single release needs the edge index to reach 'earliest'.
  logic [NC-1:0] m_fe[2];
  logic [127:0]  m_ba[2];
  int            m_earl[2];
  int            m_stag[2];
  int            edge_n;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] f, input logic b,
                              input logic [3:0] e4, input logic bz, input logic [3:0] e1,
                              input logic cb, input logic [127:0] eb);
    vec_t v;
    v.rst_before = r; v.fe = f; v.byp = b; v.exp4 = e4; v.busy4 = bz; v.exp1 = e1;
    v.chk_ba = cb; v.exp_ba = eb;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; fe = '0; byp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic void model_reset();
    edge_n = 0;
    for (int k = 0; k < 2; k++) begin
      m_fe[k] = '0; m_ba[k] = ALL_RST; m_earl[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    logic [NC-1:0] pend, rel;
    logic found;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      pend = fe & ~m_fe[k];
      rel = '0;
      if (byp) begin
        rel = pend;
        m_earl[k] = edge_n + 1;
      end else if (edge_n >= m_earl[k] && pend != 0) begin
        found = 1'b0;
        for (int i = 0; i < NC; i++) begin
          if (pend[i] && !found) begin rel[i] = 1'b1; found = 1'b1; end
        end
        m_earl[k] = edge_n + m_stag[k];
      end
      m_fe[k] = (m_fe[k] & fe) | rel;
      for (int i = 0; i < NC; i++) if (rel[i]) m_ba[k][i*32 +: 32] = ba[i*32 +: 32];
    end
  endfunction

  function automatic logic model_busy(input int k);
    return (|(fe & ~m_fe[k])) || (edge_n + 1 < m_earl[k]);
  endfunction

  initial begin
    int waited;
    rst = 1'b1; fe = '0; byp = 1'b0; ba = PATTERN;
    m_stag[0] = 4; m_stag[1] = 1;

    // Scenario 1: all four requested at once.
    add(1, 4'b1111, 0, 4'b0001, 1, 4'b0001, 0, '0);
    add(0, 4'b1111, 0, 4'b0001, 1, 4'b0011, 0, '0);
    add(0, 4'b1111, 0, 4'b0001, 1, 4'b0111, 0, '0);
    add(0, 4'b1111, 0, 4'b0001, 1, 4'b1111, 0, '0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0011, 1, 4'b1111, 0, '0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0111, 1, 4'b1111, 0, '0);
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 0, 4'b1111, 1, 4'b1111, 0, '0);
    add(0, 4'b1111, 0, 4'b1111, 0, 4'b1111, 1, PATTERN);
    // Scenario 2: lower-index request arriving during the gap is served first.
    add(1, 4'b1010, 0, 4'b0010, 1, 4'b0010, 0, '0);
    add(0, 4'b1010, 0, 4'b0010, 1, 4'b1010, 0, '0);
    add(0, 4'b1011, 0, 4'b0010, 1, 4'b1011, 0, '0);
    add(0, 4'b1011, 0, 4'b0010, 1, 4'b1011, 0, '0);
    for (int i = 0; i < 4; i++) add(0, 4'b1011, 0, 4'b0011, 1, 4'b1011, 0, '0);
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 0, 4'b1011, 1, 4'b1011, 0, '0);
    add(0, 4'b1011, 0, 4'b1011, 0, 4'b1011, 1,
        {32'h1C000300, 32'h1C000000, 32'h1C000100, 32'h1C000000});

    do_reset();
    chk("reset_fe4", fe_o4, '0);
    chk("reset_ba4", ba_o4, ALL_RST);
    chk("reset_busy4", busy4, 1'b0);
    chk("reset_busy1", busy1, 1'b0);

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst_before) do_reset();
      fe = tbl[r].fe; byp = tbl[r].byp;
      step();
      chk($sformatf("tbl%0d_fe4", r), fe_o4, tbl[r].exp4);
      chk($sformatf("tbl%0d_busy4", r), busy4, tbl[r].busy4);
      chk($sformatf("tbl%0d_fe1", r), fe_o1, tbl[r].exp1);
      if (tbl[r].chk_ba) begin
        chk($sformatf("tbl%0d_ba4", r), ba_o4, tbl[r].exp_ba);
        chk($sformatf("tbl%0d_ba1", r), ba_o1, tbl[r].exp_ba);
      end
    end

    // Scenario 3: requests dropped before and after release.
    do_reset();
    fe = 4'b1111; step(); chk("s3_e1", fe_o4, 4'b0001);
    steps(2); fe = 4'b1011; step();
    step(); chk("s3_e5", fe_o4, 4'b0011);
    step(); fe = 4'b1010; step(); chk("s3_e7", fe_o4, 4'b0010);
    step(); step(); chk("s3_e9", fe_o4, 4'b1010);
    steps(4); chk("s3_e13", fe_o4, 4'b1010); chk("s3_busy", busy4, 1'b0);

    // Scenario 4: boot address captured only at release, persists after disable.
    do_reset();
    ba = PATTERN; ba[31:0] = 32'h11110000;
    fe = 4'b0001; step();
    chk("s4_fe", fe_o4, 4'b0001);
    chk("s4_ba4", ba_o4[31:0], 32'h11110000);
    ba[31:0] = 32'hDEADBEEF; steps(3);
    chk("s4_hold4", ba_o4[31:0], 32'h11110000);
    chk("s4_hold1", ba_o1[31:0], 32'h11110000);
    fe = 4'b0000; step();
    chk("s4_off", fe_o4, 4'b0000);
    chk("s4_persist", ba_o4[31:0], 32'h11110000);
    fe = 4'b0001; waited = 0;
    do begin step(); waited++; end while (!fe_o4[0] && waited < 8);
    chk("s4_rerelease", fe_o4, 4'b0001);
    chk("s4_new4", ba_o4[31:0], 32'hDEADBEEF);
    chk("s4_new1", ba_o1[31:0], 32'hDEADBEEF);
    ba = PATTERN;

    // Scenario 5: bypass from IDLE and from GAP.
    do_reset();
    fe = 4'b1111; steps(4); chk("s5_pre", fe_o4, 4'b0001);
    byp = 1'b1; step(); byp = 1'b0;
    chk("s5_all", fe_o4, 4'b1111); chk("s5_busy", busy4, 1'b0);
    do_reset();
    fe = 4'b1111; steps(2); byp = 1'b1; step(); byp = 1'b0;
    chk("s5_gap_all", fe_o4, 4'b1111); chk("s5_gap_busy", busy4, 1'b0);
    fe = 4'b0111; step(); fe = 4'b1111; step();
    chk("s5_idle_after", fe_o4, 4'b1111);

    // Scenario 6: asynchronous reset mid-sequence.
    do_reset();
    fe = 4'b1111; steps(5); chk("s6_pre", fe_o4, 4'b0011);
    #2 rst = 1'b1; #1;
    chk("s6_async_fe4", fe_o4, '0);
    chk("s6_async_ba4", ba_o4, ALL_RST);
    chk("s6_async_fe1", fe_o1, '0);
    @(posedge clk); #1 rst = 1'b0;
    step(); chk("s6_restart", fe_o4, 4'b0001);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) fe = 4'($urandom);
      byp = ($urandom_range(0, 19) == 0);
      ba[$urandom_range(0, 3)*32 +: 32] = $urandom;
      #1;
      chk($sformatf("rnd%0d_busy4", c), busy4, model_busy(0));
      chk($sformatf("rnd%0d_busy1", c), busy1, model_busy(1));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("rnd%0d_fe4", c), fe_o4, m_fe[0]);
      chk($sformatf("rnd%0d_fe1", c), fe_o1, m_fe[1]);
      chk($sformatf("rnd%0d_ba4", c), ba_o4, m_ba[0]);
      chk($sformatf("rnd%0d_ba1", c), ba_o1, m_ba[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
